uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter. It is the responder on the CPU data-port bus: the CPU drives address, byte write enables and write data, and read data returns one cycle later. The top level decodes the peripheral window (addr[31:28]==4'hA) into sel and muxes rdata with a one-cycle-delayed sel. Bytes written by the CPU queue in a FIFO and are serialized as 8N1, LSB first, on tx.

Parameters:
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, >=2.
DIV_RESET, 16'd234, reset value of BAUDDIV (27 MHz / 115200).

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
sel  in  1  bus access targets this block this cycle
addr  in  32  byte address; only [3:2] decoded
wen  in  4  byte write enables; 0 = read
wdata  in  32  write data
rdata  out  32  registered read data, valid the cycle after a read
tx  out  1  serial output, idle high

Behaviour:
- Reset (async, immediate): tx=1, rdata=0, BAUDDIV=DIV_RESET, overflow=0, FIFO flushed, FSM=IDLE. Reset mid-frame aborts the frame; tx goes high without waiting for a clock edge.
- Register map, by addr[3:2]:
  - 0 TXDATA. A write with wen[0] pushes wdata[7:0]. Reads return 0.
  - 1 STATUS. Fields: bit0 busy (FSM!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), [11:8] FIFO count; other bits 0. A write with wen[0] and wdata[3]=1 clears overflow.
  - 2 BAUDDIV [15:0]. wen[0] writes [7:0]; wen[1] writes [15:8]. Reads return {16'h0, BAUDDIV}.
  - 3 reserved. Reads return 0; writes are ignored.
- Reads: when sel && wen==0, rdata is loaded with the selected register at the next edge; otherwise rdata holds its value. STATUS reflects its pre-edge value.
- Push rule: a push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set. Set has priority over a same-cycle clear.
- Bit period: BAUDDIV+1 cycles. BAUDDIV=0 gives 1 cycle/bit. A frame is 10*(BAUDDIV+1) cycles.
- FSM:
  - IDLE: if FIFO non-empty, pop into shift register and go to START. Otherwise stay; tx=1.
  - START: tx=0 for one bit period, then go to DATA with bit index=0.
  - DATA: tx=shift[0] each bit. Shift right at the end of each bit. After bit 7, go to STOP.
  - STOP: tx=1 for one bit period. At the end, if FIFO non-empty, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Latency: a write at edge N into an empty FIFO with FSM idle gives count=1 after N. The pop occurs at edge N+1; tx=0 from edge N+2.
- Baud counter: loaded with BAUDDIV at each bit start and decremented; the bit ends when it reaches 0. A BAUDDIV write mid-bit takes effect at the next bit start.
- tx is driven from a flop (glitch-free).

Decomposition:
- Package uart_pkg:
  - FSM state enum (IDLE, START, DATA, STOP);
  - register offset constants (TXDATA=2'd0, STATUS=2'd1, BAUDDIV=2'd2);
  - STATUS bit index constants.
- Sub-module uart_tx_fifo: synchronous FIFO with push/pop/full/empty/count, async reset, first-word-fall-through data.

Test Plan:
1. Status after reset: read STATUS after reset -> rdata=32'h0000_0004 the following cycle. Read BAUDDIV -> 32'h0000_00EA.
2. Single frame: BAUDDIV=3, write TXDATA 0x55 at edge N -> tx=0 for cycles N+2..N+5, then data bits 1,0,1,0,1,0,1,0 for 4 cycles each, then stop=1 for 4 cycles. Then STATUS busy=0 and empty=1.
3. Overflow: BAUDDIV=100, write TXDATA 10 consecutive cycles (0x00..0x09) -> 10th byte dropped, STATUS=full|overflow with count=8. Write STATUS 0x8 -> overflow=0. Line carries 0x00..0x08 in order.
4. Back-to-back frames: BAUDDIV=1, write 0xFF then 0x00 -> the stop bit of frame 1 is immediately followed by the start bit of frame 2, with no extra idle cycles. Total time is 40 cycles from the first start bit.
5. Async reset mid-frame: assert reset during data bit 3 -> tx=1 before the next clock edge. STATUS=0x4 and BAUDDIV=234 after deassertion. Queued bytes are never sent.
6. Byte enables: BAUDDIV write with wen=4'b0001 and wdata=0x0000_1210 -> BAUDDIV=0x0010. TXDATA write with wen=4'b0010 -> no push, count stays 0. Reserved-offset write -> no state change.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Register offsets, decoded from addr[3:2]
    localparam logic [1:0] TXDATA  = 2'd0;
    localparam logic [1:0] STATUS  = 2'd1;
    localparam logic [1:0] BAUDDIV = 2'd2;

    // STATUS register bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding bytes waiting to be sent.
module uart_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register file, TX FIFO and serializer.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [31:0] addr,
    input  logic [3:0]  wen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e     state_q;
    tx_state_e     state_d;
    logic [15:0]   baud_div;
    logic [15:0]   baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          overflow;
    logic          tx_d;
    logic          pop;
    logic          load_baud;
    logic          shift_adv;
    logic          bit_end;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [1:0]    reg_off;
    logic          rd_en;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          push_drop;
    logic [31:0]   status_word;
    logic [31:0]   rd_mux;
    logic          unused_bits;

    assign reg_off     = addr[3:2];
    assign rd_en       = sel && (wen == 4'b0000);
    assign wr_txdata   = sel && wen[0] && (reg_off == TXDATA);
    assign wr_status   = sel && (reg_off == STATUS);
    assign wr_baud     = sel && (reg_off == BAUDDIV);
    assign push_drop   = wr_txdata && fifo_full && !pop;
    assign bit_end     = (baud_cnt == 16'd0);
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

    uart_tx_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // STATUS word and read-data mux, both from pre-edge state
    always_comb begin
        status_word                        = '0;
        status_word[STAT_BUSY]             = (state_q != IDLE);
        status_word[STAT_FULL]             = fifo_full;
        status_word[STAT_EMPTY]            = fifo_empty;
        status_word[STAT_OVF]              = overflow;
        status_word[STAT_CNT_LSB +: 4]     = 4'(fifo_count);
        case (reg_off)
            STATUS:  rd_mux = status_word;
            BAUDDIV: rd_mux = {16'h0, baud_div};
            default: rd_mux = '0;
        endcase
    end

    // Serializer next-state, FIFO pop and bit-timing controls
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        load_baud = 1'b0;
        shift_adv = 1'b0;
        tx_d      = 1'b1;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_baud = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    load_baud = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx_d = shift[0];
                if (bit_end) begin
                    load_baud = 1'b1;
                    shift_adv = 1'b1;
                    if (bit_idx == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        load_baud = 1'b1;
                        state_d   = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and registered line output; reset forces the line idle at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tx      <= 1'b1;
        end else begin
            state_q <= state_d;
            tx      <= tx_d;
        end
    end

    // Bit timer, shift register and bit index; BAUDDIV is sampled only at bit starts
    always_ff @(posedge clk) begin
        if (load_baud) baud_cnt <= baud_div;
        else           baud_cnt <= baud_cnt - 16'd1;
        if (pop)            shift <= fifo_dout;
        else if (shift_adv) shift <= {1'b0, shift[7:1]};
        if (state_q == START) bit_idx <= 3'd0;
        else if (shift_adv)   bit_idx <= bit_idx + 3'd1;
    end

    // Bus-visible registers: divider, sticky overflow, registered read data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_div <= DIV_RESET;
            overflow <= 1'b0;
            rdata    <= '0;
        end else begin
            if (wr_baud && wen[0]) baud_div[7:0]  <= wdata[7:0];
            if (wr_baud && wen[1]) baud_div[15:8] <= wdata[15:8];
            if (push_drop)                             overflow <= 1'b1;
            else if (wr_status && wen[0] && wdata[3])  overflow <= 1'b0;
            if (rd_en) rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Testbench for uart_tx_mmio: register vectors, line timing and a serial scoreboard.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  wen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  sb[$];
    int          bit_p = 235;
    bit          mon_en = 1'b1;
    bit          mon_busy = 1'b0;
    logic [7:0]  burst_data[16];

    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vec[14];

    always #5 clk = ~clk;

    uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_RESET(16'd234)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .wen   (wen),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; wen = we; wdata = d;
        @(negedge clk);
        sel = 1'b0; wen = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; addr = a; wen = 4'h0;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic set_div(input logic [15:0] v);
        bus_write(32'hA000_0008, 4'b0011, {16'h0, v});
        bit_p = int'(v) + 1;
    endtask

    // Consecutive-cycle TXDATA writes; returns at the negedge after the last write edge
    task automatic burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sel = 1'b1; addr = 32'hA000_0000; wen = 4'b0001; wdata = {24'h0, burst_data[i]};
        end
        @(negedge clk);
        sel = 1'b0; wen = 4'h0;
    endtask

    // Cycle-exact line check: k counts edges after the first write, frames start at k=2
    task automatic check_line(input int k0, input int kend, input int nfr, input int p);
        logic [7:0] bd;
        int rel, f, b;
        logic e;
        for (int k = k0; k <= kend; k++) begin
            @(negedge clk);
            rel = k - 2;
            e = 1'b1;
            if (rel >= 0) begin
                f = rel / (10 * p);
                b = (rel % (10 * p)) / p;
                if (f < nfr) begin
                    bd = burst_data[f];
                    if (b == 0)      e = 1'b0;
                    else if (b == 9) e = 1'b1;
                    else             e = bd[b-1];
                end
            end
            check($sformatf("line_k%0d", k), {31'h0, tx}, {31'h0, e});
        end
    endtask

    // Serial monitor: decodes each frame and compares it with the expected-byte queue
    initial begin
        logic [7:0] got;
        int p;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx === 1'b0) begin
                mon_busy = 1'b1;
                p = bit_p;
                for (int i = 0; i < 8; i++) begin
                    repeat (p) @(negedge clk);
                    got[i] = tx;
                end
                repeat (p) @(negedge clk);
                check("mon_stop", {31'h0, tx}, 32'h1);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL mon_unexpected: got byte %h, expected no frame", got);
                end else begin
                    check("mon_byte", {24'h0, got}, {24'h0, sb.pop_front()});
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int zeros;
        int waited;

        vec[0]  = '{1'b0, 32'hA000_0004, 4'h0, 32'h0,         32'h0000_0004};
        vec[1]  = '{1'b0, 32'hA000_0008, 4'h0, 32'h0,         32'h0000_00EA};
        vec[2]  = '{1'b0, 32'hA000_0000, 4'h0, 32'h0,         32'h0000_0000};
        vec[3]  = '{1'b0, 32'hA000_000C, 4'h0, 32'h0,         32'h0000_0000};
        vec[4]  = '{1'b1, 32'hA000_0008, 4'h1, 32'h0000_1210, 32'h0};
        vec[5]  = '{1'b0, 32'hA000_0008, 4'h0, 32'h0,         32'h0000_0010};
        vec[6]  = '{1'b1, 32'hA000_0008, 4'h2, 32'h0000_3400, 32'h0};
        vec[7]  = '{1'b0, 32'hA000_0008, 4'h0, 32'h0,         32'h0000_3410};
        vec[8]  = '{1'b1, 32'hA000_0000, 4'h2, 32'h0000_00AA, 32'h0};
        vec[9]  = '{1'b0, 32'hA000_0004, 4'h0, 32'h0,         32'h0000_0004};
        vec[10] = '{1'b1, 32'hA000_000C, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vec[11] = '{1'b0, 32'hA000_0008, 4'h0, 32'h0,         32'h0000_3410};
        vec[12] = '{1'b0, 32'hA000_0004, 4'h0, 32'h0,         32'h0000_0004};
        vec[13] = '{1'b0, 32'hA000_000C, 4'h0, 32'h0,         32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", {31'h0, tx}, 32'h1);
        check("reset_rdata", rdata, 32'h0);
        reset = 1'b0;

        // Register map, byte enables, reserved offset
        for (int i = 0; i < 14; i++) begin
            if (vec[i].is_wr) begin
                bus_write(vec[i].a, vec[i].we, vec[i].d);
            end else begin
                bus_read(vec[i].a, rd);
                check($sformatf("vec%0d_rdata", i), rd, vec[i].exp);
            end
        end

        // Single frame, 4 cycles per bit
        set_div(16'd3);
        burst_data[0] = 8'h55;
        sb.push_back(8'h55);
        burst(1);
        check_line(1, 44, 1, 4);
        bus_read(32'hA000_0004, rd);
        check("single_status", rd, 32'h0000_0004);

        // Overflow: ten writes into an eight-entry FIFO while one byte is in flight
        set_div(16'd100);
        for (int i = 0; i < 10; i++) burst_data[i] = 8'(i);
        for (int i = 0; i < 9; i++) sb.push_back(8'(i));
        burst(10);
        bus_read(32'hA000_0004, rd);
        check("ovf_status", rd, 32'h0000_080B);
        bus_write(32'hA000_0004, 4'h1, 32'h0000_0008);
        bus_read(32'hA000_0004, rd);
        check("ovf_cleared", rd, 32'h0000_0803);
        waited = 0;
        while (waited < 12000 && (sb.size() != 0 || mon_busy)) begin
            @(negedge clk);
            waited++;
        end
        check("ovf_drained", sb.size(), 0);
        repeat (300) @(negedge clk);
        bus_read(32'hA000_0004, rd);
        check("ovf_idle_status", rd, 32'h0000_0004);

        // Back-to-back frames, 2 cycles per bit, no gap between stop and start
        set_div(16'd1);
        burst_data[0] = 8'hFF;
        burst_data[1] = 8'h00;
        sb.push_back(8'hFF);
        sb.push_back(8'h00);
        burst(2);
        check_line(2, 44, 2, 2);
        bus_read(32'hA000_0004, rd);
        check("b2b_status", rd, 32'h0000_0004);

        // Asynchronous reset during data bit 3 of 0xA5
        mon_en = 1'b0;
        set_div(16'd3);
        burst_data[0] = 8'hA5;
        burst_data[1] = 8'h3C;
        burst(2);
        repeat (18) @(negedge clk);
        check("pre_reset_tx", {31'h0, tx}, 32'h0);
        #2 reset = 1'b1;
        #1;
        check("async_reset_tx", {31'h0, tx}, 32'h1);
        check("async_reset_rdata", rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(32'hA000_0004, rd);
        check("post_reset_status", rd, 32'h0000_0004);
        bus_read(32'hA000_0008, rd);
        check("post_reset_div", rd, 32'h0000_00EA);
        zeros = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) zeros++;
        end
        check("post_reset_line_idle", zeros, 0);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
